keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_if.sv | 13 +
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: row drive / column sense toward the keypad,
// read strobe and status word toward the CPU IO decoder.
interface keypad_scanner_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_rd;
  logic [11:0] key_data;

  // Scanner side
  modport slave  (output row, output key_data, input col, input key_rd);
  // Board / CPU side
  modport master (input row, input key_data, output col, output key_rd);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a registered
// CPU status word {pending, overrun, count[5:0], code[3:0]}.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_scanner_if.slave  bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DB_N = 4'(DEBOUNCE_N);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  logic [3:0]       col_s1_q, col_s2_q;
  logic             rd_prev_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       r_q;
  logic [3:0]       row_q;
  logic [1:0]       acc_cnt_q;   // low columns so far this scan, saturated at 2
  logic [3:0]       acc_key_q;
  state_t           state_q, state_d;
  logic [3:0]       db_q, db_d;
  logic [3:0]       cand_q, cand_d;
  logic             pending_q, overrun_q;
  logic [5:0]       count_q;
  logic [3:0]       code_q;

  logic             div_tc, scan_v, accept, rd_edge;
  logic [3:0]       low;
  logic [2:0]       pop, sum;
  logic [1:0]       col_idx, base_cnt, cnt_new;
  logic [3:0]       base_key, key_new, db_inc;
  logic             res_none, res_single;

  assign div_tc     = (div_q == DIV_LAST);
  assign scan_v     = div_tc && (r_q == 2'd3);
  assign rd_edge    = bus.key_rd && !rd_prev_q;
  assign res_none   = (cnt_new == 2'd0);
  assign res_single = (cnt_new == 2'd1);
  assign db_inc     = db_q + 4'd1;

  // Two-flop column synchronizer and read-strobe history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q  <= '1;
      col_s2_q  <= '1;
      rd_prev_q <= 1'b0;
    end else begin
      col_s1_q  <= bus.col;
      col_s2_q  <= col_s1_q;
      rd_prev_q <= bus.key_rd;
    end
  end

  // Merge this row's sample into the running scan result
  always_comb begin
    low     = ~col_s2_q;
    pop     = '0;
    col_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (low[i]) begin
        pop     = pop + 3'd1;
        col_idx = 2'(i);
      end
    end
    base_cnt = (r_q == 2'd0) ? 2'd0 : acc_cnt_q;
    base_key = (r_q == 2'd0) ? 4'd0 : acc_key_q;
    sum      = {1'b0, base_cnt} + pop;
    cnt_new  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    key_new  = base_key;
    if (base_cnt == 2'd0 && pop == 3'd1) key_new = {r_q, col_idx};
  end

  // Row divider, row drive and per-scan accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      r_q       <= '0;
      row_q     <= 4'b1110;
      acc_cnt_q <= '0;
      acc_key_q <= '0;
    end else if (div_tc) begin
      div_q     <= '0;
      r_q       <= r_q + 2'd1;
      row_q     <= ~(4'b0001 << (r_q + 2'd1));
      acc_cnt_q <= cnt_new;
      acc_key_q <= key_new;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Debounce FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      db_q    <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      cand_q  <= cand_d;
    end
  end

  // Debounce FSM next state; evaluated once per full scan
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (scan_v) begin
      unique case (state_q)
        IDLE: begin
          if (res_single) begin
            cand_d = key_new;
            db_d   = 4'd1;
            if (DB_N == 4'd1) begin
              accept  = 1'b1;
              state_d = HELD;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (res_single && key_new == cand_q) begin
            db_d = db_inc;
            if (db_inc == DB_N) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else begin
            db_d    = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (res_none) begin
            if (DB_N == 4'd1) begin
              db_d    = '0;
              state_d = IDLE;
            end else begin
              db_d    = 4'd1;
              state_d = RELEASE_DB;
            end
          end
        end
        RELEASE_DB: begin
          if (res_none) begin
            db_d = db_inc;
            if (db_inc == DB_N) begin
              db_d    = '0;
              state_d = IDLE;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // CPU status word; a press accept outranks a simultaneous read clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
      code_q    <= '0;
    end else if (accept) begin
      code_q    <= cand_d;
      count_q   <= count_q + 6'd1;
      pending_q <= 1'b1;
      overrun_q <= rd_edge ? 1'b0 : (overrun_q | pending_q);
    end else if (rd_edge) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign bus.row      = row_q;
  assign bus.key_data = {pending_q, overrun_q, count_q, code_q};

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_N=2).
module tb_keypad_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DN = 2;
  localparam int unsigned SCAN_CYC = 4 * SD;

  logic        clk;
  logic        rst_n;
  logic [15:0] mask;      // pressed keys, bit k = 4*row + col
  logic [3:0]  col_drv;

  keypad_scanner_if bus ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_N(DN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a pressed key shorts its row line to its column line
  always_comb begin
    col_drv = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!bus.row[r] && mask[4*r+c]) col_drv[c] = 1'b0;
  end
  assign bus.col = col_drv;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  bit   m_pending, m_overrun, m_held, m_rd_prev;
  int   m_count, m_run_len, m_none_run;
  logic [3:0] m_code, m_run_key;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
  endtask

  function automatic logic [11:0] exp_word();
    return {m_pending, m_overrun, 6'(m_count), m_code};
  endfunction

  task automatic model_reset();
    m_pending = 0; m_overrun = 0; m_held = 0; m_rd_prev = 0;
    m_count = 0; m_run_len = 0; m_none_run = 0;
    m_code = '0; m_run_key = '0;
  endtask

  // One complete scan seen as a set of pressed keys
  task automatic model_scan(input logic [15:0] m, input bit rd_edge);
    int pc;
    logic [3:0] key;
    bit acc;
    pc  = $countones(m);
    key = '0;
    acc = 0;
    for (int k = 0; k < 16; k++) if (m[k]) key = 4'(k);
    if (!m_held) begin
      if (pc == 1 && (m_run_len == 0 || key == m_run_key)) begin
        if (m_run_len == 0) m_run_key = key;
        m_run_len++;
      end else begin
        m_run_len = 0;
      end
      if (m_run_len == int'(DN)) begin
        acc = 1;
        m_held = 1; m_none_run = 0; m_run_len = 0;
      end
    end else begin
      if (pc == 0) m_none_run++;
      else m_none_run = 0;
      if (m_none_run == int'(DN)) begin
        m_held = 0; m_run_len = 0;
      end
    end
    if (acc) begin
      m_code    = m_run_key;
      m_count   = (m_count + 1) % 64;
      m_overrun = rd_edge ? 1'b0 : (m_overrun | m_pending);
      m_pending = 1;
    end else if (rd_edge) begin
      m_pending = 0;
      m_overrun = 0;
    end
  endtask

  // One full scan with the given keys held; key_rd high on cycles
  // [rd_at, rd_at+rd_len) of the scan (rd_at < 0: no read).
  // Entered and left at posedge+1.
  task automatic do_scan(input logic [15:0] m, input int rd_at, input int rd_len);
    bit rd, edge_now;
    logic [3:0] one, exp_row;
    one  = 4'b0001;
    mask = m;
    for (int i = 0; i < int'(SCAN_CYC); i++) begin
      rd = (rd_at >= 0) && (i >= rd_at) && (i < rd_at + rd_len);
      bus.key_rd = rd;
      @(posedge clk);
      edge_now  = rd && !m_rd_prev;
      m_rd_prev = rd;
      if (i == int'(SCAN_CYC) - 1) model_scan(m, edge_now);
      else if (edge_now) begin
        m_pending = 0;
        m_overrun = 0;
      end
      #1;
      exp_row = ~(one << (((i + 1) / int'(SD)) % 4));
      check("key_data", bus.key_data, exp_word());
      check("row", 12'(bus.row), 12'(exp_row));
    end
  endtask

  // Asynchronous reset pulse between clock edges; released at posedge+1
  task automatic do_reset();
    bus.key_rd = 1'b0;
    rst_n = 1'b0;
    #2;
    check("reset_key_data", bus.key_data, 12'h000);
    check("reset_row", 12'(bus.row), 12'h00E);
    model_reset();
    @(posedge clk);
    #1;
    check("reset_hold_row", 12'(bus.row), 12'h00E);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rm;
    int hold, rd_at;
    rst_n = 1'b0;
    bus.key_rd = 1'b0;
    mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_key_data", bus.key_data, 12'h000);
    check("por_row", 12'(bus.row), 12'h00E);
    rst_n = 1'b1;

    // Row 2 / column 1 held for three scans
    do_scan(16'(1 << 9), -1, 0);
    do_scan(16'(1 << 9), -1, 0);
    check("first_accept", bus.key_data, 12'h819);
    do_scan(16'(1 << 9), -1, 0);
    check("held_no_repeat", bus.key_data, 12'h819);

    // Release, then row 0 / column 3 without a read
    repeat (3) do_scan('0, -1, 0);
    repeat (3) do_scan(16'(1 << 3), -1, 0);
    check("overrun", bus.key_data, 12'hC23);

    // Read strobe held five cycles clears once
    do_scan('0, 2, 5);
    check("read_clear", bus.key_data, 12'h023);
    do_scan('0, -1, 0);

    // One-scan bounce, then two keys together
    do_scan(16'(1 << 5), -1, 0);
    do_scan('0, -1, 0);
    check("bounce", bus.key_data, 12'h023);
    repeat (4) do_scan(16'((1 << 5) | (1 << 10)), -1, 0);
    check("multi", bus.key_data, 12'h023);
    do_scan('0, -1, 0);

    // Accept with pending set, then accept coinciding with a read edge
    repeat (2) do_scan(16'(1 << 6), -1, 0);
    check("accept_3", bus.key_data, 12'h836);
    repeat (2) do_scan('0, -1, 0);
    do_scan(16'(1 << 12), -1, 0);
    do_scan(16'(1 << 12), int'(SCAN_CYC) - 1, 1);
    check("read_and_accept", bus.key_data, 12'h84C);
    repeat (2) do_scan('0, -1, 0);

    // Reset in the middle of press debounce; key re-debounced afterwards
    do_scan(16'(1 << 1), -1, 0);
    mask = 16'(1 << 1);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    do_scan(16'(1 << 1), -1, 0);
    check("after_reset_pending", bus.key_data, 12'h000);
    do_scan(16'(1 << 1), -1, 0);
    check("recount", bus.key_data, 12'h811);

    // Randomized key patterns and reads against the model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0, 1: rm = '0;
        2:    rm = 16'(1 << $urandom_range(0, 15));
        default: begin
          rm = 16'(1 << $urandom_range(0, 15));
          rm = rm | 16'(1 << $urandom_range(0, 15));
        end
      endcase
      hold = int'($urandom_range(1, 4));
      for (int h = 0; h < hold; h++) begin
        rd_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
        do_scan(rm, rd_at, int'($urandom_range(1, 6)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
